// File: rtl/scalar_fu_issuer.sv
// scalar_fu_issuer
// ----------------
// Initiator side of the scalar functional-unit handshake. Accepts operand
// pairs on a valid/ready input, runs one operation at a time on an attached
// adder-class FU (registered result, ack one cycle after on_off, ack held
// while on_off is high), and buffers results in a small first-word
// fall-through FIFO that drains over a valid/ready output.
//
// Optional feature: define SCALAR_FU_ISSUER_TIMEOUT_EN to add a WAIT-state
// watchdog. It aborts an operation after TIMEOUT cycles without ack and sets
// the sticky timeout_err output. Without the macro the port does not exist.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake, in_a/in_b operands
//   out_valid/out_ready result handshake, out_c = FIFO head (0 when empty)
//   fu_a/fu_b/fu_on_off registered drive to the FU
//   fu_c/fu_ack         FU result and completion
//   busy                state != IDLE
//   timeout_err         sticky abort flag (optional feature only)
module scalar_fu_issuer #(
    parameter int WIDTH     = 16,
    parameter int RES_DEPTH = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic             fu_on_off,
    input  logic [WIDTH-1:0] fu_c,
    input  logic             fu_ack,
    output logic             busy
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  fu_a_q, fu_a_d;
    logic [WIDTH-1:0]  fu_b_q, fu_b_d;
    logic              fu_on_off_q, fu_on_off_d;

    logic [WIDTH-1:0]  mem_q [RES_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_s;
    logic              pop_s;
    logic              accept_s;

`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // Circular pointer advance; wraps at RES_DEPTH (need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RES_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign in_ready  = (state_q == IDLE) && (count_q < CW'(RES_DEPTH));
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (count_q != CW'(0));
    assign pop_s     = out_valid && out_ready;
    assign out_c     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign fu_on_off = fu_on_off_q;
    assign busy      = (state_q != IDLE);
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

    // Handshake FSM: next state, FU drive and result push.
    always_comb begin
        state_d     = state_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_on_off_d = fu_on_off_q;
        push_s      = 1'b0;
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A spurious fu_ack here is deliberately ignored.
                if (accept_s) begin
                    fu_a_d      = in_a;
                    fu_b_d      = in_b;
                    fu_on_off_d = 1'b1;
                    state_d     = WAIT;
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Ack has priority over a same-cycle timeout. The slot is
                // guaranteed free because acceptance required one.
                if (fu_ack) begin
                    push_s      = 1'b1;
                    fu_on_off_d = 1'b0;
                    state_d     = RELEASE;
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT-th WAIT cycle without ack: abort, nothing pushed.
                    fu_on_off_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`else
                end else begin
                    state_d = WAIT;
                end
`endif
            end
            RELEASE: begin
                // Wait for the FU to drop ack so the next op sees a clean edge.
                if (!fu_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d     = IDLE;
                fu_on_off_d = 1'b0;
            end
        endcase
    end

    // Result FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State, FU drive and FIFO control registers; reset aborts and flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_on_off_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_on_off_q <= fu_on_off_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef SCALAR_FU_ISSUER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // FIFO storage; contents need no reset because out_c is gated by occupancy.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_q[wr_ptr_q] <= fu_c;
        end
    end

endmodule
